// File: rtl/branch_prediction_table.sv
// Branch direction predictor: table of saturating counters indexed by PC, optionally gshare-folded
// with a global history register, plus a one-entry-per-cycle clear sweep.
module branch_prediction_table #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned PC_LSB    = 2,
    parameter int unsigned HIST_BITS = 0
) (
    input  logic                                         bpt_clk,
    input  logic                                         bpt_rst,
    input  logic                                         bpt_lookup_valid,
    input  logic [PC_BITS-1:0]                           bpt_lookup_pc,
    output logic                                         bpt_pred_valid,
    output logic                                         bpt_pred_taken,
    output logic [CTR_BITS-1:0]                          bpt_pred_counter,
    output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] bpt_pred_hist,
    input  logic                                         bpt_update_valid,
    input  logic [PC_BITS-1:0]                           bpt_update_pc,
    input  logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] bpt_update_hist,
    input  logic                                         bpt_update_taken,
    input  logic                                         bpt_clear,
    output logic                                         bpt_busy
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned HW       = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_BITS-1:0]   sweep_idx;
    logic [HW-1:0]         ghr;
    logic [HW-1:0]         ghr_shift;
    logic [CTR_BITS-1:0]   table_q [ENTRIES];

    logic [IDX_BITS-1:0]   lk_base;
    logic [IDX_BITS-1:0]   up_base;
    logic [IDX_BITS-1:0]   lk_idx;
    logic [IDX_BITS-1:0]   up_idx;
    logic [CTR_BITS-1:0]   up_new;
    logic [CTR_BITS-1:0]   lk_ctr;

    logic                  do_lookup;
    logic                  do_update;
    logic                  do_start;
    logic                  do_sweep;

    logic                  unused_pc_bits;
    assign unused_pc_bits = ^{bpt_lookup_pc, bpt_update_pc, bpt_update_hist};

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                     input logic               taken);
        if (taken) begin
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        end
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    assign lk_base = bpt_lookup_pc[PC_LSB +: IDX_BITS];
    assign up_base = bpt_update_pc[PC_LSB +: IDX_BITS];

    // Index folding and history shift depend on whether history is configured at all.
    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign lk_idx    = lk_base;
            assign up_idx    = up_base;
            assign ghr_shift = '0;
        end else begin : g_gshare
            assign lk_idx = lk_base ^ IDX_BITS'(ghr);
            assign up_idx = up_base ^ IDX_BITS'(bpt_update_hist);
            if (HIST_BITS == 1) begin : g_h1
                assign ghr_shift = bpt_update_taken;
            end else begin : g_hn
                assign ghr_shift = {ghr[HW-2:0], bpt_update_taken};
            end
        end
    endgenerate

    assign up_new = sat_step(table_q[up_idx], bpt_update_taken);

    // Write-first bypass: a same-cycle update to the looked-up entry is visible in the prediction.
    always_comb begin
        lk_ctr = table_q[lk_idx];
        if (do_update && (up_idx == lk_idx)) begin
            lk_ctr = up_new;
        end
    end

    always_ff @(posedge bpt_clk or posedge bpt_rst) begin
        if (bpt_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bpt_clear) state_next = CLEAR;
            CLEAR:   if (sweep_idx == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        do_lookup = 1'b0;
        do_update = 1'b0;
        do_start  = 1'b0;
        do_sweep  = 1'b0;
        case (state)
            IDLE: begin
                do_lookup = bpt_lookup_valid;
                do_update = bpt_update_valid && !bpt_clear;
                do_start  = bpt_clear;
            end
            CLEAR:   do_sweep = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge bpt_clk or posedge bpt_rst) begin
        if (bpt_rst) begin
            sweep_idx <= '0;
            ghr       <= '0;
        end else if (do_start) begin
            sweep_idx <= '0;
            ghr       <= '0;
        end else begin
            if (do_sweep) begin
                sweep_idx <= sweep_idx + IDX_BITS'(1);
            end
            if (do_update) begin
                ghr <= ghr_shift;
            end
        end
    end

    always_ff @(posedge bpt_clk or posedge bpt_rst) begin
        if (bpt_rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (do_sweep) begin
            table_q[sweep_idx] <= CTR_INIT;
        end else if (do_update) begin
            table_q[up_idx] <= up_new;
        end
    end

    // Prediction outputs hold their last values between accepted lookups.
    always_ff @(posedge bpt_clk or posedge bpt_rst) begin
        if (bpt_rst) begin
            bpt_pred_valid   <= 1'b0;
            bpt_pred_taken   <= 1'b0;
            bpt_pred_counter <= '0;
            bpt_pred_hist    <= '0;
            bpt_busy         <= 1'b0;
        end else begin
            bpt_pred_valid <= do_lookup;
            bpt_busy       <= (state_next == CLEAR);
            if (do_lookup) begin
                bpt_pred_counter <= lk_ctr;
                bpt_pred_taken   <= lk_ctr[CTR_BITS-1];
                bpt_pred_hist    <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_branch_prediction_table.sv
// Directed bench for branch_prediction_table: a bimodal instance and a 4-bit gshare instance.
module tb_branch_prediction_table;

    logic        clk = 1'b0;
    logic        rst;

    logic        lv, uv, ut, clr;
    logic [31:0] lpc, upc;
    logic        pv, pt, busy;
    logic [1:0]  pc_ctr;
    logic [0:0]  ph;
    logic [0:0]  uh;

    logic        g_lv, g_uv, g_ut, g_clr;
    logic [31:0] g_lpc, g_upc;
    logic        g_pv, g_pt, g_busy;
    logic [1:0]  g_ctr;
    logic [3:0]  g_ph, g_uh;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_prediction_table u_bim (
        .bpt_clk(clk), .bpt_rst(rst),
        .bpt_lookup_valid(lv), .bpt_lookup_pc(lpc),
        .bpt_pred_valid(pv), .bpt_pred_taken(pt), .bpt_pred_counter(pc_ctr), .bpt_pred_hist(ph),
        .bpt_update_valid(uv), .bpt_update_pc(upc), .bpt_update_hist(uh), .bpt_update_taken(ut),
        .bpt_clear(clr), .bpt_busy(busy)
    );

    branch_prediction_table #(.HIST_BITS(4)) u_gsh (
        .bpt_clk(clk), .bpt_rst(rst),
        .bpt_lookup_valid(g_lv), .bpt_lookup_pc(g_lpc),
        .bpt_pred_valid(g_pv), .bpt_pred_taken(g_pt), .bpt_pred_counter(g_ctr), .bpt_pred_hist(g_ph),
        .bpt_update_valid(g_uv), .bpt_update_pc(g_upc), .bpt_update_hist(g_uh), .bpt_update_taken(g_ut),
        .bpt_clear(g_clr), .bpt_busy(g_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lv = 1'b1; lpc = pc;
        tick();
        lv = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input int n);
        for (int i = 0; i < n; i++) begin
            uv = 1'b1; upc = pc; ut = taken;
            tick();
        end
        uv = 1'b0;
    endtask

    task automatic g_update(input logic [31:0] pc, input logic [3:0] h, input logic taken);
        g_uv = 1'b1; g_upc = pc; g_uh = h; g_ut = taken;
        tick();
        g_uv = 1'b0;
    endtask

    task automatic g_lookup(input logic [31:0] pc);
        g_lv = 1'b1; g_lpc = pc;
        tick();
        g_lv = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        lv = 0; uv = 0; ut = 0; clr = 0; lpc = 0; upc = 0; uh = 0;
        g_lv = 0; g_uv = 0; g_ut = 0; g_clr = 0; g_lpc = 0; g_upc = 0; g_uh = 0;
        repeat (2) tick();
        check("rst_pred_valid", 32'(pv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pred_counter", 32'(pc_ctr), 32'd0);
        rst = 1'b0;
        tick();

        lookup(32'h40);
        check("init_valid", 32'(pv), 32'd1);
        check("init_counter", 32'(pc_ctr), 32'd1);
        check("init_taken", 32'(pt), 32'd0);
        tick();
        check("hold_valid", 32'(pv), 32'd0);
        check("hold_counter", 32'(pc_ctr), 32'd1);

        update(32'h40, 1'b1, 4);
        lookup(32'h40);
        check("sat_hi_counter", 32'(pc_ctr), 32'd3);
        check("sat_hi_taken", 32'(pt), 32'd1);
        update(32'h40, 1'b0, 4);
        lookup(32'h40);
        check("sat_lo_counter", 32'(pc_ctr), 32'd0);
        lookup(32'h80);
        check("alias_counter", 32'(pc_ctr), 32'd0);

        // Same-cycle lookup/update on one entry, then on different entries.
        lv = 1'b1; lpc = 32'h44; uv = 1'b1; upc = 32'h44; ut = 1'b1;
        tick();
        lv = 1'b0; uv = 1'b0;
        check("bypass_counter", 32'(pc_ctr), 32'd2);
        check("bypass_taken", 32'(pt), 32'd1);
        lv = 1'b1; lpc = 32'h48; uv = 1'b1; upc = 32'h50; ut = 1'b1;
        tick();
        lv = 1'b0; uv = 1'b0;
        check("nobypass_counter", 32'(pc_ctr), 32'd1);

        // gshare history folding.
        g_update(32'h0, 4'd0, 1'b1);
        g_update(32'h0, 4'd1, 1'b1);
        g_update(32'h0, 4'd3, 1'b0);
        g_lookup(32'h0);
        check("gs_valid", 32'(g_pv), 32'd1);
        check("gs_hist", 32'(g_ph), 32'h6);
        check("gs_idx6_counter", 32'(g_ctr), 32'd1);
        g_lookup(32'h14);
        check("gs_idx3_counter", 32'(g_ctr), 32'd0);
        g_lookup(32'h1c);
        check("gs_idx1_counter", 32'(g_ctr), 32'd2);

        // Clear sweep: lookup served and update dropped in the start cycle.
        update(32'h4c, 1'b1, 2);
        lookup(32'h4c);
        check("train_idx3", 32'(pc_ctr), 32'd3);
        clr = 1'b1; lv = 1'b1; lpc = 32'h4c; uv = 1'b1; upc = 32'h4c; ut = 1'b0;
        tick();
        clr = 1'b0; lv = 1'b0; uv = 1'b0;
        check("clr_lookup_valid", 32'(pv), 32'd1);
        check("clr_update_dropped", 32'(pc_ctr), 32'd3);
        check("clr_busy_start", 32'(busy), 32'd1);
        clr = 1'b1; lv = 1'b1; lpc = 32'h4c; uv = 1'b1; upc = 32'h54; ut = 1'b1;
        tick();
        clr = 1'b0; lv = 1'b0; uv = 1'b0;
        check("busy_no_pred", 32'(pv), 32'd0);
        n = 2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        check("busy_cycles", 32'(n), 32'd16);
        lookup(32'h4c);
        check("cleared_idx3", 32'(pc_ctr), 32'd1);
        lookup(32'h54);
        check("busy_update_dropped_idx5", 32'(pc_ctr), 32'd1);
        lookup(32'h44);
        check("cleared_idx1", 32'(pc_ctr), 32'd1);

        // Reset mid-sweep.
        update(32'h70, 1'b1, 2);
        lookup(32'h70);
        check("train_idx12", 32'(pc_ctr), 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (6) tick();
        check("sweep_busy_c7", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        lookup(32'h70);
        check("rst_idx12_init", 32'(pc_ctr), 32'd1);
        check("rst_then_valid", 32'(pv), 32'd1);
        g_lookup(32'h18);
        check("rst_ghr_zero", 32'(g_ph), 32'h0);
        check("rst_gs_idx6_init", 32'(g_ctr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_prediction_table.md
Name: branch_prediction_table

Overview:
- Parametrised branch direction predictor: an array of ENTRIES saturating counters, each CTR_BITS wide.
- Indexed by fetch PC, optionally XOR-folded with a global history register (gshare mode when HIST_BITS > 0).
- Sits beside fetch: the lookup port returns a registered prediction one cycle later; the resolve port from execute trains the counters.
- A clear sweep re-initialises the table on demand.

Parameters:
- ENTRIES, 16, number of counters; power of 2, minimum 2; IDX_BITS = log2(ENTRIES).
- CTR_BITS, 2, counter width; range 1..4.
- PC_BITS, 32, width of PC inputs.
- PC_LSB, 2, lowest PC bit used for indexing; index bits are pc[PC_LSB+IDX_BITS-1 : PC_LSB].
- HIST_BITS, 0, global history length; 0 = bimodal, otherwise 1..IDX_BITS.

Ports:
- bpt_clk  in  1  clock, rising edge.
- bpt_rst  in  1  asynchronous, active-high reset.
- bpt_lookup_valid  in  1  lookup request this cycle.
- bpt_lookup_pc  in  PC_BITS  PC to predict.
- bpt_pred_valid  out  1  prediction valid; pulses one cycle after an accepted lookup.
- bpt_pred_taken  out  1  predicted direction (counter MSB).
- bpt_pred_counter  out  CTR_BITS  raw counter value used for the prediction.
- bpt_pred_hist  out  max(HIST_BITS,1)  history snapshot used for the lookup index; 0 when HIST_BITS=0.
- bpt_update_valid  in  1  branch resolved this cycle.
- bpt_update_pc  in  PC_BITS  PC of the resolved branch.
- bpt_update_hist  in  max(HIST_BITS,1)  history snapshot returned with the branch; ignored when HIST_BITS=0.
- bpt_update_taken  in  1  actual outcome.
- bpt_clear  in  1  synchronous pulse that starts a clear sweep.
- bpt_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async):
  - All counters = INIT = 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 for CTR_BITS=2; 0 for CTR_BITS=1).
  - GHR = 0, state IDLE, sweep index 0.
  - bpt_pred_valid=0, bpt_pred_taken=0, bpt_pred_counter=0, bpt_pred_hist=0, bpt_busy=0.
- Index computation:
  - base = PC index bits.
  - HIST_BITS>0: lookup idx = base XOR zero-extended GHR; update idx = base XOR zero-extended bpt_update_hist.
  - HIST_BITS=0: idx = base.
- Lookup:
  - Accepted when bpt_lookup_valid=1 in IDLE.
  - Next cycle: bpt_pred_valid=1; pred_counter = counter[idx]; pred_taken = pred_counter[CTR_BITS-1]; pred_hist = GHR sampled in the lookup cycle.
  - Fixed latency 1; back-to-back lookups every cycle are supported.
- Update:
  - In IDLE with bpt_update_valid=1, counter[update idx] saturates at the clock edge:
    - taken: +1 unless at 2^CTR_BITS-1;
    - not taken: -1 unless at 0.
  - GHR <= {GHR[HIST_BITS-2:0], taken}; for HIST_BITS=1, GHR <= taken.
- Same-cycle lookup and update to the same index: the prediction reflects the post-update counter (write-first bypass). Lookup index uses the GHR value before that cycle's shift.
- Clear state machine (IDLE, CLEAR):
  - IDLE -> CLEAR when bpt_clear=1: sweep index=0, GHR=0, bpt_busy=1 from the next cycle.
  - In CLEAR: counter[sweep index] = INIT each cycle, sweep index increments.
  - After writing entry ENTRIES-1, return to IDLE; busy lasts exactly ENTRIES cycles.
  - bpt_clear while in CLEAR is ignored; the sweep does not restart.
  - bpt_clear and bpt_update_valid together in IDLE: the update is dropped.
  - bpt_clear and bpt_lookup_valid together in IDLE: the lookup is still served.
- During CLEAR: lookups are not accepted (pred_valid=0 the next cycle); updates are dropped and GHR does not shift.
- Reset mid-sweep aborts immediately to the reset state.
- bpt_pred_* hold their last values when bpt_pred_valid=0.

Test Plan:
- After reset (ENTRIES=16, CTR_BITS=2, HIST_BITS=0): lookup pc=0x40 -> next cycle pred_valid=1, counter=2'b01, taken=0.
- Four taken updates at pc=0x40, then lookup -> counter=2'b11, taken=1 (saturated). Then 4 not-taken updates -> counter=2'b00. Lookup pc=0x80 (aliases idx 0) -> counter=00.
- Lookup and taken update at pc=0x44 in the same cycle from INIT -> pred_counter=2'b10, taken=1 (bypass). Lookup pc=0x48 in that same cycle -> unaffected, counter=01.
- HIST_BITS=4: updates taken,taken,not-taken at pc=0x0 (hist inputs 0,1,3) -> GHR=4'b0110. Lookup pc=0x0 -> pred_hist=0110, counter read from idx 6 = 01.
- Train idx 3 to 11, pulse bpt_clear -> busy high exactly 16 cycles. Lookup during busy -> no pred_valid; update during busy -> idx 5 stays 01. After busy drops, lookup idx 3 -> 01.
- Assert bpt_rst for 1 cycle mid-sweep (cycle 7) -> busy=0 immediately, GHR=0, all counters INIT.
